// File: rtl/const_op_pkg.sv
// const_op_pkg: opcode and state types shared by the operator unit, its bus and its divider.
package const_op_pkg;
    localparam int WIDTH_DEFAULT = 32;
    typedef enum logic [4:0] {
        ADD = 5'd0, SUB, MUL, DIV, MOD, EQ, NE, LT, LE, GT, GE, LNOT, BNOT, SHL, ASHL, SHR, ASHR, SEL
    } op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;
endpackage

// File: rtl/const_op_if.sv
// const_op_if: request/result handshake bus between the operator unit and its neighbours.
interface const_op_if
    import const_op_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_div_zero;
    modport master (
        output in_valid, in_op, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_result, out_div_zero
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_result, out_div_zero
    );
endinterface

// File: rtl/const_op_div.sv
// const_op_div: unsigned restoring divider, one quotient bit per cycle starting on the start edge.
module const_op_div
    import const_op_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dsr, rem_src, quo_src, dsr_src, rem_nxt;
    logic [WIDTH:0]   trial;
    assign busy = cnt != '0;
    // The start edge already performs the first iteration so the last bit lands WIDTH-1 edges later.
    always_comb begin
        rem_src = start ? '0 : remainder;
        quo_src = start ? dividend : quotient;
        dsr_src = start ? divisor : dsr;
        trial   = {rem_src, quo_src[WIDTH-1]} - {1'b0, dsr_src};
        rem_nxt = trial[WIDTH] ? {rem_src[WIDTH-2:0], quo_src[WIDTH-1]} : trial[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                remainder <= rem_nxt;
                quotient  <= {quo_src[WIDTH-2:0], ~trial[WIDTH]};
                dsr       <= dsr_src;
                cnt       <= start ? CW'(WIDTH - 1) : cnt - 1'b1;
                done      <= start ? (WIDTH == 1) : (cnt == CW'(1));
            end
        end
    end
endmodule

// File: rtl/const_op_unit.sv
// const_op_unit: sequential int operator unit; single-cycle ALU ops plus an iterative signed divide.
module const_op_unit
    import const_op_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    const_op_if.slave bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DIV  = ST_DIV;
    localparam logic [1:0] S_DONE = ST_DONE;
    logic [1:0]       state;
    logic [WIDTH-1:0] alu, abs_a, abs_b, quo, rem, result;
    logic             div_op, accept, start, div_busy, div_done, is_mod, neg_q, neg_r, div_zero;
    logic signed [WIDTH-1:0] sa, sb;
    assign sa = bus.in_a;
    assign sb = bus.in_b;
    assign div_op = bus.in_op == DIV || bus.in_op == MOD;
    assign bus.in_ready = !div_busy && (state == S_IDLE || (state == S_DONE && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;
    assign start = accept && div_op && bus.in_b != '0;
    assign abs_a = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign abs_b = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
    assign bus.out_valid = state == S_DONE;
    assign bus.out_result = result;
    assign bus.out_div_zero = div_zero;
    // DIV/MOD entries here are only used for a zero divisor; nonzero divisors go through the divider.
    always_comb begin
        case (bus.in_op)
            ADD:       alu = bus.in_a + bus.in_b;
            SUB:       alu = bus.in_a - bus.in_b;
            MUL:       alu = bus.in_a * bus.in_b;
            DIV:       alu = '1;
            MOD:       alu = bus.in_a;
            EQ:        alu = WIDTH'(sa == sb);
            NE:        alu = WIDTH'(sa != sb);
            LT:        alu = WIDTH'(sa < sb);
            LE:        alu = WIDTH'(sa <= sb);
            GT:        alu = WIDTH'(sa > sb);
            GE:        alu = WIDTH'(sa >= sb);
            LNOT:      alu = WIDTH'(bus.in_a == '0);
            BNOT:      alu = ~bus.in_a;
            SHL, ASHL: alu = bus.in_a << bus.in_b;
            SHR:       alu = bus.in_a >> bus.in_b;
            ASHR:      alu = sa >>> bus.in_b;
            SEL:       alu = bus.in_a != '0 ? bus.in_b : bus.in_c;
            default:   alu = '0;
        endcase
    end
    const_op_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (abs_a),
        .divisor  (abs_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo),
        .remainder(rem)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            result   <= '0;
            div_zero <= 1'b0;
            is_mod   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (start) begin
            state  <= S_DIV;
            is_mod <= bus.in_op == MOD;
            neg_q  <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
            neg_r  <= bus.in_a[WIDTH-1];
        end else if (accept) begin
            state    <= S_DONE;
            result   <= alu;
            div_zero <= div_op;
        end else if (state == S_DIV && div_done) begin
            state    <= S_DONE;
            result   <= is_mod ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
            div_zero <= 1'b0;
        end else if (state == S_DONE && bus.out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_const_op_unit.sv
// tb_const_op_unit: directed vector table, corner sequences and randomized checks against an arithmetic model.
module tb_const_op_unit;
    import const_op_pkg::*;
    localparam int MIN_INT = int'(32'h8000_0000);
    typedef struct {
        op_t         op;
        int          a;
        int          b;
        int          c;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    const_op_if #(.WIDTH(32)) bus ();
    const_op_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    // Returns {div_zero, result} straight from the operator definitions.
    function automatic logic [32:0] model(input op_t op, input int a, input int b, input int c);
        int   r = 0;
        logic dz = 1'b0;
        logic big = $unsigned(b) >= 32;
        case (op)
            ADD:       r = a + b;
            SUB:       r = a - b;
            MUL:       r = a * b;
            DIV:       if (b == 0) begin dz = 1'b1; r = -1; end
                       else if (a == MIN_INT && b == -1) r = MIN_INT;
                       else r = a / b;
            MOD:       if (b == 0) begin dz = 1'b1; r = a; end
                       else if (b == -1) r = 0;
                       else r = a % b;
            EQ:        r = int'(a == b);
            NE:        r = int'(a != b);
            LT:        r = int'(a < b);
            LE:        r = int'(a <= b);
            GT:        r = int'(a > b);
            GE:        r = int'(a >= b);
            LNOT:      r = int'(a == 0);
            BNOT:      r = ~a;
            SHL, ASHL: r = big ? 0 : a << b;
            SHR:       r = big ? 0 : int'($unsigned(a) >> b);
            ASHR:      r = big ? (a < 0 ? -1 : 0) : a >>> b;
            SEL:       r = a != 0 ? b : c;
            default:   r = 0;
        endcase
        return {dz, r};
    endfunction
    function automatic int pick();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return -1;
            2: return MIN_INT;
            3: return int'($urandom_range(0, 40));
            4: return -int'($urandom_range(1, 40));
            default: return int'($urandom);
        endcase
    endfunction
    // Called at a negedge; returns at the negedge where the result is first seen.
    task automatic do_op(input op_t op, input int a, input int b, input int c,
                         output logic [31:0] res, output logic dz, output int lat);
        int guard = 0;
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_c = c;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        while (!bus.in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!bus.out_valid) lat = 999;
        res = bus.out_result;
        dz = bus.out_div_zero;
    endtask
    initial begin
        logic [31:0] res;
        logic        dz;
        int          lat, held, xfers, stale;
        logic [32:0] exp;
        tbl.push_back('{ADD, 42, 19, 0, 32'd61, 1'b0, 1});
        tbl.push_back('{SUB, 42, 19, 0, 32'd23, 1'b0, 1});
        tbl.push_back('{MUL, 42, 19, 0, 32'd798, 1'b0, 1});
        tbl.push_back('{EQ, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{NE, 42, 19, 0, 32'd1, 1'b0, 1});
        tbl.push_back('{GE, 42, 19, 0, 32'd1, 1'b0, 1});
        tbl.push_back('{GT, 42, 19, 0, 32'd1, 1'b0, 1});
        tbl.push_back('{LE, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{LT, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{LNOT, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{BNOT, 42, 19, 0, 32'd4294967253, 1'b0, 1});
        tbl.push_back('{SHL, 42, 19, 0, 32'd22020096, 1'b0, 1});
        tbl.push_back('{ASHL, 42, 19, 0, 32'd22020096, 1'b0, 1});
        tbl.push_back('{SHR, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{ASHR, 42, 19, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{DIV, 42, 19, 0, 32'd2, 1'b0, 33});
        tbl.push_back('{MOD, 42, 19, 0, 32'd4, 1'b0, 33});
        tbl.push_back('{DIV, -42, 19, 0, 32'hFFFF_FFFE, 1'b0, 33});
        tbl.push_back('{MOD, -42, 19, 0, 32'hFFFF_FFFC, 1'b0, 33});
        tbl.push_back('{DIV, 42, -19, 0, 32'hFFFF_FFFE, 1'b0, 33});
        tbl.push_back('{MOD, 42, -19, 0, 32'd4, 1'b0, 33});
        tbl.push_back('{SEL, 0, 42, 9001, 32'd9001, 1'b0, 1});
        tbl.push_back('{SEL, 1, 42, 9001, 32'd42, 1'b0, 1});
        tbl.push_back('{ASHR, -42, 1, 0, 32'hFFFF_FFEB, 1'b0, 1});
        tbl.push_back('{ASHR, -42, 40, 0, 32'hFFFF_FFFF, 1'b0, 1});
        tbl.push_back('{DIV, 7, 0, 0, 32'hFFFF_FFFF, 1'b1, 1});
        tbl.push_back('{MOD, 7, 0, 0, 32'd7, 1'b1, 1});
        tbl.push_back('{ADD, 1, 2, 0, 32'd3, 1'b0, 1});
        tbl.push_back('{DIV, MIN_INT, -1, 0, 32'h8000_0000, 1'b0, 33});
        tbl.push_back('{MOD, MIN_INT, -1, 0, 32'd0, 1'b0, 33});
        tbl.push_back('{SHR, -1, 31, 0, 32'd1, 1'b0, 1});
        tbl.push_back('{SHR, -1, 32, 0, 32'd0, 1'b0, 1});
        tbl.push_back('{SHL, 1, 31, 0, 32'h8000_0000, 1'b0, 1});
        tbl.push_back('{LNOT, 0, 0, 0, 32'd1, 1'b0, 1});
        tbl.push_back('{op_t'(5'd25), 42, 19, 7, 32'd0, 1'b0, 1});
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_op = ADD; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_result", bus.out_result, 32'd0);
        check("reset_div_zero", 32'(bus.out_div_zero), 32'd0);
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, res, dz, lat);
            check($sformatf("vec%0d_%s_result", i, tbl[i].op.name()), res, tbl[i].res);
            check($sformatf("vec%0d_%s_div_zero", i, tbl[i].op.name()), 32'(dz), 32'(tbl[i].dz));
            check($sformatf("vec%0d_%s_latency", i, tbl[i].op.name()), lat, tbl[i].lat);
        end
        // Backpressure: result and valid must hold with the unit refusing new work.
        bus.in_op = ADD; bus.in_a = 5; bus.in_b = 6; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        held = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_result == 32'd11 && !bus.in_ready) held++;
        end
        check("backpressure_hold", held, 5);
        bus.out_ready = 1'b1;
        xfers = 0;
        repeat (4) begin
            #1;
            if (bus.out_valid) xfers++;
            @(negedge clk);
        end
        check("backpressure_single_transfer", xfers, 1);
        // Reset ten cycles into a divide must discard it.
        bus.in_op = DIV; bus.in_a = 1000; bus.in_b = 3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("abort_no_stale_result", stale, 0);
        do_op(ADD, 1, 1, 0, res, dz, lat);
        check("abort_add_result", res, 32'd2);
        check("abort_add_latency", lat, 1);
        for (int i = 0; i < 200; i++) begin
            op_t op;
            int  a, b, c;
            op = op_t'($urandom_range(0, 20));
            a = pick(); b = pick(); c = pick();
            exp = model(op, a, b, c);
            do_op(op, a, b, c, res, dz, lat);
            check($sformatf("rnd%0d_%0d_result", i, op), res, exp[31:0]);
            check($sformatf("rnd%0d_%0d_div_zero", i, op), 32'(dz), 32'(exp[32]));
            check($sformatf("rnd%0d_%0d_latency", i, op), lat, ((op == DIV || op == MOD) && b != 0) ? 33 : 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/const_op_unit.md
Name: const_op_unit

Overview:
- Sequential 32-bit integer operator unit that evaluates the SystemVerilog binary, unary and ternary operator set on `int` operands.
- Sits directly upstream of the parameter/value consumer stage. It receives operands and an opcode over a valid/ready handshake and delivers one registered result per operation.
- Single-cycle ops complete in 1 cycle. Divide and modulo use an iterative restoring divider.

Parameters:
- WIDTH, 32: operand/result width; operands are two's-complement signed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  5  opcode (const_op_pkg::op_t)
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_c  in  WIDTH  operand c (SEL only)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_div_zero  out  1  DIV/MOD had b==0

Behaviour:
- Reset values:
  - in_ready=1 (after reset), out_valid=0, out_result=0, out_div_zero=0.
  - State IDLE.
  - rst mid-DIV aborts the division; no result is emitted.
- States:
  - IDLE
  - DIV (iterating)
  - DONE (out_valid=1)
- Handshake:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept when in_valid && in_ready. out_* hold stable while out_valid && !out_ready.
- Single-cycle ops: accepted at edge t → DONE with out_valid from t+1. Back-to-back accept in DONE gives 1 op/cycle.
- DIV/MOD: accepted at t → DIV for WIDTH cycles → out_valid at t+WIDTH+1. in_ready=0 while in DIV.
- Divide by zero: go to DONE at t+1 with out_div_zero=1. DIV result is all-ones; MOD result is a.
- Opcodes (all arithmetic mod 2^WIDTH):
  - ADD, SUB, MUL: low WIDTH bits of the result.
  - DIV: signed, truncates toward zero.
  - MOD: sign follows dividend.
  - EQ, NE, LT, LE, GT, GE: signed compare; result zero-extended 0/1.
  - LNOT: a==0 → 1, else 0.
  - BNOT: ~a.
  - SHL, ASHL: identical; b is unsigned; b≥WIDTH gives 0.
  - SHR: logical right shift; b≥WIDTH gives 0.
  - ASHR: sign-fill right shift; b≥WIDTH gives all copies of a[WIDTH-1].
  - SEL: a!=0 ? b : c.
- Overflow: MIN_INT / -1 gives MIN_INT; MIN_INT % -1 gives 0.
- Undefined opcode: result 0 with normal single-cycle latency.
- out_div_zero is 0 for every op except zero-divisor DIV/MOD.

Decomposition:
- const_op_pkg holds:
  - op_t enum, 5 bits: ADD=0, SUB, MUL, DIV, MOD, EQ, NE, LT, LE, GT, GE, LNOT, BNOT, SHL, ASHL, SHR, ASHR, SEL.
  - state_t enum.
  - WIDTH_DEFAULT constant.
- One sub-module: const_op_div.
  - Unsigned restoring divider: start/busy/done, WIDTH cycles.
  - const_op_unit handles sign correction of quotient and remainder.

Test Plan:
- a=42, b=19, out_ready=1, ops ADD/SUB/MUL/EQ/NE/GE/GT/LE/LT/LNOT/BNOT/SHL/ASHL/SHR/ASHR issued back-to-back → results 61, 23, 798, 0, 1, 1, 1, 0, 0, 0, 4294967253, 22020096, 22020096, 0, 0; one result per cycle.
- DIV and MOD with a=42, b=19 → 2 and 4, out_valid exactly WIDTH+1=33 cycles after accept. With a=-42, b=19 → 0xFFFFFFFE and 0xFFFFFFFC.
- SEL: a=0, b=42, c=9001 → 9001. a=1 → 42. ASHR a=-42, b=1 → 0xFFFFFFEB. ASHR a=-42, b=40 → 0xFFFFFFFF.
- DIV a=7, b=0 → result 0xFFFFFFFF, out_div_zero=1 at t+1. MOD a=7, b=0 → 7. Next ADD clears out_div_zero.
- Backpressure: out_ready=0 for 5 cycles after an ADD result → out_result and out_valid held, in_ready=0. Release gives exactly one transfer.
- rst asserted 10 cycles into a DIV → next cycle out_valid=0, in_ready=1. A following ADD 1+1 → 2 with no stale result emitted.
